// File: rtl/pipeline_flush_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_flush_ctrl
// Decides branches in the ID stage using operands forwarded from EX/MEM, and
// squashes IF/ID for the cycle of a taken branch plus FLUSH_DEPTH more cycles.
// The flush counter freezes while the pipeline is stalled.
//
// Optional feature: define PIPELINE_FLUSH_BNE_EN to decode bne as a
// conditional branch (taken when operands differ). Without it, bne is
// treated as a non-branch.
//
// Opcode encodings come from the shared OP_* macros; local fallbacks are
// provided so the block also builds on its own.
// ---------------------------------------------------------------------------
`ifndef OP_BEQ
`define OP_BEQ 4'h8
`endif
`ifndef OP_BNE
`define OP_BNE 4'h9
`endif
`ifndef OP_B
`define OP_B   4'hA
`endif
`ifndef OP_BL
`define OP_BL  4'hB
`endif
`ifndef OP_BR
`define OP_BR  4'hC
`endif

module pipeline_flush_ctrl #(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int FLUSH_DEPTH = 1,
    parameter int CW          = $clog2(FLUSH_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [3:0]        opcode,
    input  logic [REG_W-1:0]  ID_rs,
    input  logic [REG_W-1:0]  ID_rt,
    input  logic [DATA_W-1:0] ID_read_data_1,
    input  logic [DATA_W-1:0] ID_read_data_2,
    input  logic [REG_W-1:0]  EX_rt_rd,
    input  logic              EX_reg_write,
    input  logic [DATA_W-1:0] EX_alu_out,
    input  logic [REG_W-1:0]  MEM_rt_rd,
    input  logic              MEM_reg_write,
    input  logic [DATA_W-1:0] MEM_data,
    output logic              IF_ID_sync_nop,
    output logic              branch_taken,
    output logic              flush_busy,
    output logic [CW-1:0]     flush_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Operand forwarding: the youngest producer (EX) wins over MEM.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        op_a = ID_read_data_1;
        if (EX_reg_write && (EX_rt_rd == ID_rs))
            op_a = EX_alu_out;
        else if (MEM_reg_write && (MEM_rt_rd == ID_rs))
            op_a = MEM_data;

        op_b = ID_read_data_2;
        if (EX_reg_write && (EX_rt_rd == ID_rt))
            op_b = EX_alu_out;
        else if (MEM_reg_write && (MEM_rt_rd == ID_rt))
            op_b = MEM_data;
    end

    // Branch decision on the forwarded operands.
    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            `OP_B, `OP_BL, `OP_BR: branch_taken = 1'b1;
            `OP_BEQ:               branch_taken = (op_a == op_b);
`ifdef PIPELINE_FLUSH_BNE_EN
            `OP_BNE:               branch_taken = (op_a != op_b);
`endif
            default:               branch_taken = 1'b0;
        endcase
    end

    // Zero-latency squash on the decision cycle, then hold it while flushing.
    assign IF_ID_sync_nop = flush_busy | branch_taken;

    // Flush FSM with registered busy/count; reset overrides stall, and
    // branches are only looked at while IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_busy  <= 1'b0;
            flush_count <= '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        state       <= FLUSH;
                        flush_busy  <= 1'b1;
                        flush_count <= CW'(FLUSH_DEPTH);
                    end
                end
                FLUSH: begin
                    if (flush_count == CW'(1)) begin
                        state       <= IDLE;
                        flush_busy  <= 1'b0;
                        flush_count <= '0;
                    end else begin
                        flush_count <= flush_count - CW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    flush_busy  <= 1'b0;
                    flush_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_flush_ctrl
// Directed bench: one instance with FLUSH_DEPTH=3 and one with FLUSH_DEPTH=1
// share all inputs. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pipeline_flush_ctrl;

    localparam logic [3:0] NOP    = 4'h0;
    localparam logic [3:0] OP_BEQ = 4'h8;
    localparam logic [3:0] OP_BNE = 4'h9;
    localparam logic [3:0] OP_B   = 4'hA;
    localparam logic [3:0] OP_BR  = 4'hC;

`ifdef PIPELINE_FLUSH_BNE_EN
    localparam int BNE_TAKEN = 1;
`else
    localparam int BNE_TAKEN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [3:0]  opcode;
    logic [3:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic [15:0] rd1, rd2, ex_alu, mem_data;
    logic        ex_we, mem_we;

    logic        nop0, taken0, busy0;
    logic [1:0]  cnt0;
    logic        nop1, taken1, busy1;
    logic [0:0]  cnt1;

    int total  = 0;
    int passed = 0;
    int n0, n1, nops;

    always #5 clk = ~clk;

    pipeline_flush_ctrl #(.DATA_W(16), .REG_W(4), .FLUSH_DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .opcode(opcode),
        .ID_rs(id_rs), .ID_rt(id_rt),
        .ID_read_data_1(rd1), .ID_read_data_2(rd2),
        .EX_rt_rd(ex_rd), .EX_reg_write(ex_we), .EX_alu_out(ex_alu),
        .MEM_rt_rd(mem_rd), .MEM_reg_write(mem_we), .MEM_data(mem_data),
        .IF_ID_sync_nop(nop0), .branch_taken(taken0),
        .flush_busy(busy0), .flush_count(cnt0)
    );

    pipeline_flush_ctrl #(.DATA_W(16), .REG_W(4), .FLUSH_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .opcode(opcode),
        .ID_rs(id_rs), .ID_rt(id_rt),
        .ID_read_data_1(rd1), .ID_read_data_2(rd2),
        .EX_rt_rd(ex_rd), .EX_reg_write(ex_we), .EX_alu_out(ex_alu),
        .MEM_rt_rd(mem_rd), .MEM_reg_write(mem_we), .MEM_data(mem_data),
        .IF_ID_sync_nop(nop1), .branch_taken(taken1),
        .flush_busy(busy1), .flush_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Count squash cycles of both instances over a fixed 12-cycle window,
    // starting with the current cycle; opcode drops to NOP after the first.
    task automatic run_flush(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 12; i++) begin
            if (nop0) c0++;
            if (nop1) c1++;
            cyc();
            opcode = NOP;
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; opcode = NOP;
        id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
        rd1 = '0; rd2 = '0; ex_alu = '0; mem_data = '0;
        ex_we = 1'b0; mem_we = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("reset_busy", busy0, 0);
        check("reset_count", cnt0, 0);
        check("reset_nop", nop0, 0);

        // Unconditional branch: 4 squash cycles, count 3,2,1,0.
        opcode = OP_B;
        #1;
        check("b_taken", taken0, 1);
        check("b_nop_zero_latency", nop0, 1);
        check("b_busy_before_edge", busy0, 0);
        cyc(); opcode = NOP; #1;
        check("b_count3", cnt0, 3);
        check("b_busy", busy0, 1);
        check("b_nop_c3", nop0, 1);
        cyc(); opcode = OP_B; #1;
        check("b_count2", cnt0, 2);
        check("b_nop_c2", nop0, 1);
        cyc(); opcode = NOP; #1;
        check("b_no_reload_count1", cnt0, 1);
        check("b_busy_c1", busy0, 1);
        cyc(); #1;
        check("b_done_count", cnt0, 0);
        check("b_done_busy", busy0, 0);
        check("b_done_nop", nop0, 0);

        // beq with EX forwarding on rt.
        id_rs = 4'd2; id_rt = 4'd3; rd1 = 16'd5; rd2 = 16'd9;
        ex_rd = 4'd3; ex_we = 1'b1; ex_alu = 16'd5;
        opcode = OP_BEQ;
        #1;
        check("beq_ex_fwd_taken", taken0, 1);
        run_flush(n0, n1);
        check("beq_ex_fwd_nops", n0, 4);
        ex_we = 1'b0;
        opcode = OP_BEQ;
        #1;
        check("beq_no_fwd_taken", taken0, 0);
        check("beq_no_fwd_nop", nop0, 0);
        opcode = NOP;

        // EX beats MEM when both write rs.
        rd1 = 16'd5; rd2 = 16'd7;
        ex_rd = 4'd2; ex_we = 1'b1; ex_alu = 16'd7;
        mem_rd = 4'd2; mem_we = 1'b1; mem_data = 16'd8;
        opcode = OP_BEQ;
        #1;
        check("beq_ex_prio_taken", taken0, 1);
        run_flush(n0, n1);
        check("beq_ex_prio_nops", n0, 4);
        rd2 = 16'd8;
        opcode = OP_BEQ;
        #1;
        check("beq_ex_prio_not_taken", taken0, 0);
        ex_we = 1'b0;
        #1;
        check("beq_mem_fwd_taken", taken0, 1);
        run_flush(n0, n1);
        check("beq_mem_fwd_nops", n0, 4);
        mem_we = 1'b0;

        // br with a 2-cycle stall at count 2: 6 squash cycles total.
        nops = 0;
        opcode = OP_BR;
        #1;
        if (nop0) nops++;
        cyc(); opcode = NOP; #1;
        if (nop0) nops++;
        check("br_count3", cnt0, 3);
        cyc(); #1;
        if (nop0) nops++;
        check("br_count2", cnt0, 2);
        stall = 1'b1;
        cyc(); #1;
        if (nop0) nops++;
        check("stall1_count_hold", cnt0, 2);
        check("stall1_nop", nop0, 1);
        cyc(); #1;
        if (nop0) nops++;
        check("stall2_count_hold", cnt0, 2);
        check("stall2_busy", busy0, 1);
        stall = 1'b0;
        cyc(); #1;
        if (nop0) nops++;
        check("br_count1", cnt0, 1);
        cyc(); #1;
        if (nop0) nops++;
        check("br_done_count", cnt0, 0);
        check("br_total_nops", nops, 6);

        // Stall in IDLE with a taken branch: squash held, FLUSH deferred.
        stall = 1'b1;
        opcode = OP_B;
        #1;
        check("idle_stall_nop", nop0, 1);
        cyc(); #1;
        check("idle_stall_busy", busy0, 0);
        check("idle_stall_nop_held", nop0, 1);
        stall = 1'b0;
        cyc(); opcode = NOP; #1;
        check("idle_stall_release_busy", busy0, 1);
        check("idle_stall_release_count", cnt0, 3);
        run_flush(n0, n1);
        check("idle_stall_remaining_nops", n0, 3);

        // Reset (together with stall) aborts a flush at count 2.
        opcode = OP_B;
        cyc(); opcode = NOP;
        cyc(); #1;
        check("rst_pre_count", cnt0, 2);
        rst = 1'b1; stall = 1'b1;
        cyc();
        rst = 1'b0; stall = 1'b0;
        #1;
        check("rst_abort_busy", busy0, 0);
        check("rst_abort_count", cnt0, 0);
        check("rst_abort_nop", nop0, 0);
        opcode = OP_B;
        #1;
        run_flush(n0, n1);
        check("rst_restart_nops", n0, 4);

        // bne: configuration dependent.
        id_rs = 4'd2; id_rt = 4'd3; rd1 = 16'd4; rd2 = 16'd6;
        opcode = OP_BNE;
        #1;
        check("bne_taken", taken0, BNE_TAKEN);
        run_flush(n0, n1);
        check("bne_nops", n0, (BNE_TAKEN != 0) ? 4 : 0);

        // FLUSH_DEPTH=1: exactly 2 squash cycles.
        opcode = OP_B;
        #1;
        run_flush(n0, n1);
        check("depth1_nops", n1, 2);
        check("depth3_nops", n0, 4);
        check("depth1_idle_count", cnt1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
